// File: rtl/ex_mem_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_pipe_reg
// Description : Elastic EX->MEM pipeline register with valid/ready handshake,
//               synchronous flush and an optional two-entry skid buffer.
//               Define EXMEM_SKID_EN to build the skid buffer variant, which
//               makes in_ready a registered signal. Without it a single entry
//               is kept and in_ready is combinational from out_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_pipe_reg #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,

  // EX side
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              memWriteE,
  input  logic              regWriteE,
  input  logic              luiE,
  input  logic [1:0]        resultSrcE,
  input  logic [REG_AW-1:0] RdE,
  input  logic [XLEN-1:0]   ALUResultE,
  input  logic [XLEN-1:0]   writeDataE,
  input  logic [XLEN-1:0]   PCPlus4E,
  input  logic [XLEN-1:0]   extImmE,

  // MEM side
  output logic              out_valid,
  input  logic              out_ready,
  output logic              memWriteM,
  output logic              regWriteM,
  output logic              luiM,
  output logic [1:0]        resultSrcM,
  output logic [REG_AW-1:0] RdM,
  output logic [XLEN-1:0]   ALUResultM,
  output logic [XLEN-1:0]   writeDataM,
  output logic [XLEN-1:0]   PCPlus4M,
  output logic [XLEN-1:0]   extImmM
);

  // Whole payload is stored as one flat vector so the main and skid entries
  // share a single packing order.
  localparam int PW = 3 + 2 + REG_AW + 4 * XLEN;

  logic [PW-1:0] in_pl;
  logic [PW-1:0] main_pl;
  logic          main_valid;
  logic          accept;
  logic          drain;

  // Raw control bits of the main entry, gated below before leaving the block.
  logic          main_mem_write;
  logic          main_reg_write;
  logic          main_lui;

  assign in_pl = {memWriteE, regWriteE, luiE, resultSrcE, RdE,
                  ALUResultE, writeDataE, PCPlus4E, extImmE};

  assign accept = in_valid && in_ready;
  assign drain  = main_valid && out_ready;

`ifdef EXMEM_SKID_EN

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] skid_pl;
  logic          ready_q;

  // Two-entry occupancy tracking; ready_q mirrors (state != FULL) as a flop
  // so that in_ready never depends combinationally on out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      main_valid <= 1'b0;
      ready_q    <= 1'b1;
      main_pl    <= '0;
      skid_pl    <= '0;
    end else if (flush) begin
      // Both entries are dropped; payload bits are left as they are since
      // out_valid=0 already gates the control bits.
      state      <= EMPTY;
      main_valid <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_pl    <= in_pl;
            main_valid <= 1'b1;
            state      <= ONE;
          end
        end
        ONE: begin
          if (accept && !drain) begin
            // Consumer stalled: park the new item behind the main entry.
            skid_pl <= in_pl;
            ready_q <= 1'b0;
            state   <= FULL;
          end else if (!accept && drain) begin
            main_valid <= 1'b0;
            state      <= EMPTY;
          end else if (accept && drain) begin
            main_pl <= in_pl;
          end
        end
        FULL: begin
          if (drain) begin
            main_pl <= skid_pl;
            ready_q <= 1'b1;
            state   <= ONE;
          end
        end
        default: begin
          state      <= EMPTY;
          main_valid <= 1'b0;
          ready_q    <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready = ready_q;

`else

  typedef enum logic {
    EMPTY = 1'b0,
    ONE   = 1'b1
  } state_t;

  state_t state;

  // Single-entry register; a new item can only enter an occupied stage when
  // the current one leaves in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      main_valid <= 1'b0;
      main_pl    <= '0;
    end else if (flush) begin
      state      <= EMPTY;
      main_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_pl    <= in_pl;
            main_valid <= 1'b1;
            state      <= ONE;
          end
        end
        ONE: begin
          if (accept) begin
            main_pl <= in_pl;
          end else if (drain) begin
            main_valid <= 1'b0;
            state      <= EMPTY;
          end
        end
      endcase
    end
  end

  assign in_ready = !main_valid || out_ready;

`endif

  assign {main_mem_write, main_reg_write, main_lui, resultSrcM, RdM,
          ALUResultM, writeDataM, PCPlus4M, extImmM} = main_pl;

  assign out_valid = main_valid;

  // A bubble must never write the register file or memory.
  assign memWriteM = main_mem_write & main_valid;
  assign regWriteM = main_reg_write & main_valid;
  assign luiM      = main_lui       & main_valid;

endmodule
`default_nettype wire

// File: doc/ex_mem_pipe_reg.md
# ex_mem_pipe_reg

Parametrised, elastic EX→MEM pipeline register for the pipelined RISC-V core. It carries the execute-stage payload (ALU result, store data, PC+4, extended immediate, destination register and control bits) into the memory stage. It adds a valid/ready handshake, a synchronous flush for branch/exception squash, and an optional two-entry skid buffer so upstream ready is a registered signal. Throughput is one instruction per cycle.

## Interface
- XLEN, 32, datapath width of ALUResult, writeData, PCPlus4, extImm
- REG_AW, 5, destination register index width
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  squash all held entries (synchronous)
- in_valid  in  1  EX payload valid
- in_ready  out  1  stage can accept; transfer when in_valid && in_ready
- memWriteE, regWriteE, luiE  in  1 each  EX control bits
- resultSrcE  in  2  writeback mux select
- RdE  in  REG_AW  destination register
- ALUResultE, writeDataE, PCPlus4E, extImmE  in  XLEN each  EX data
- out_valid  out  1  MEM payload valid
- out_ready  in  1  MEM consumes; transfer when out_valid && out_ready
- memWriteM, regWriteM, luiM, resultSrcM, RdM, ALUResultM, writeDataM, PCPlus4M, extImmM  out  widths as E counterparts  MEM payload

## Operation
- Storage: main entry (drives outputs) plus skid entry (only when EXMEM_SKID_EN is defined).
- States (skid build): EMPTY, ONE, FULL; in_ready = (state != FULL), taken from a register.
- EMPTY: accept → main ← input, go to ONE.
- ONE: accept and no drain → skid ← input, go to FULL. Drain and no accept → EMPTY. Accept and drain together → main ← input, stay in ONE.
- FULL: drain → main ← skid, go to ONE. No accept is possible in FULL.
- Priority: rst > flush > handshake.
- flush: go to EMPTY and force out_valid=0 on the next edge. Any input offered in the flush cycle is discarded, even if in_valid && in_ready.
- Control gating: regWriteM, memWriteM and luiM are forced to 0 whenever out_valid=0, so a bubble can never write. resultSrcM, RdM and the data outputs hold their last value when empty.
- While out_valid && !out_ready, all M outputs are held bit-stable.
- No arithmetic is performed. Payload is passed through unmodified at XLEN/REG_AW width.

## Timing
- Reset: state EMPTY, out_valid=0, in_ready=1. All M outputs are 0: memWriteM, regWriteM, luiM = 0; resultSrcM=2'b0; RdM=0; the four data outputs = 0.
- Latency: 1 cycle. A payload accepted at edge N appears on the outputs with out_valid=1 after edge N.
- in_ready has no combinational path from out_ready in the skid build.
- Back-to-back flow at out_ready=1 gives 1 transfer per cycle with no bubbles.
- When out_ready drops, at most one further input is absorbed (into skid) before in_ready falls.
- Reset or flush asserted mid-stream discards both entries. The next accepted item is the first to emerge.

## Configuration
- EXMEM_SKID_EN defined: two-entry skid buffer as above, with registered in_ready.
- EXMEM_SKID_EN undefined: single entry only, states EMPTY/ONE.
  - in_ready = !out_valid || out_ready, which is combinational from out_ready.
  - Latency, flush, gating and reset behaviour are identical to the skid build.

## Test plan
- Reset then idle: rst=1 for 2 cycles → out_valid=0, in_ready=1, all M outputs 0, regWriteM=0.
- Streaming: in_valid=1 with ALUResultE=0x10,0x11,0x12 on consecutive cycles, out_ready=1 → the same values appear one cycle later on consecutive cycles, no gaps.
- Backpressure (skid): out_ready=0 while 0xA0 then 0xA1 are sent → in_ready falls after the second accept, and 0xA0 holds stable. Releasing out_ready → 0xA0 then 0xA1 delivered in order with nothing lost or duplicated.
- Flush: FULL state with regWriteE=1 entries, flush=1 together with in_valid=1 carrying 0xBB → next cycle out_valid=0 and regWriteM=0, and 0xBB never appears.
- Control gating: an accepted entry with memWriteE=1 is drained while out_ready=1 and in_valid=0 → memWriteM returns to 0 the cycle out_valid falls, while RdM and ALUResultM keep their last value.
- Build without EXMEM_SKID_EN: out_ready=0 with an entry held → in_ready=0 in the same cycle. Raising out_ready → in_ready=1 combinationally, and accept and drain occur in one cycle.
